prefetch_ctrl: RTL and testbench

Instruction prefetch controller for the 8-bit core. It issues sequential reads to program memory and buffers returned instruction bytes in an `en_shift_reg` instance, generating that register's per-word enables. It presents the oldest buffered byte to the decoder with a valid/ready handshake. A redirect from the loop logic flushes the buffer and restarts fetching at a new address.

---
 rtl/bf8b_pkg.sv | 7 +
 rtl/en_shift_reg.sv | 19 +
 rtl/prefetch_ctrl.sv | 63 ++++++
 tb/tb_prefetch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bf8b_pkg.sv
// bf8b_pkg: shared constants for the 8-bit core (prefetch depth, instruction and address widths, idle no-op byte)
package bf8b_pkg;
  localparam int PREFETCH_DEPTH_DEFAULT = 4;
  localparam int INSTR_WIDTH = 8;
  localparam int PC_WIDTH = 12;
  localparam logic [INSTR_WIDTH-1:0] INSTR_IDLE = '1;
endpackage

// File: rtl/en_shift_reg.sv
// en_shift_reg: LENGTH-word shift register with per-word enables; ports clk, rst, en[LENGTH], d (into word 0), q[LENGTH] (words reset to all ones)
module en_shift_reg #(
  parameter int LENGTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LENGTH-1:0]             en,
  input  logic [WIDTH-1:0]              d,
  output logic [LENGTH-1:0][WIDTH-1:0]  q
);
  always_ff @(posedge clk)
    if (rst) q <= '1;
    else begin
      if (en[0]) q[0] <= d;
      for (int i = 1; i < LENGTH; i++)
        if (en[i]) q[i] <= q[i-1];
    end
endmodule

// File: rtl/prefetch_ctrl.sv
// prefetch_ctrl: instruction prefetch buffer; ports clk, rst, redirect/redirect_addr, mem_rd/mem_addr/mem_data, instr/instr_valid/instr_ready; PREFETCH_BYPASS_EN adds empty-buffer mem_data-to-instr bypass
module prefetch_ctrl
  import bf8b_pkg::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH_DEFAULT,
  parameter int WIDTH = INSTR_WIDTH,
  parameter int ADDR_WIDTH = PC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0]      mem_data,
  output logic [WIDTH-1:0]      instr,
  output logic                  instr_valid,
  input  logic                  instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0] count;
  logic inflight, kill, push, pop, byp;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0][WIDTH-1:0] q;
  logic [WIDTH-1:0] head;
  en_shift_reg #(.LENGTH(DEPTH), .WIDTH(WIDTH)) u_buf (
    .clk(clk), .rst(rst), .en(en), .d(mem_data), .q(q)
  );
  assign mem_rd = !rst && !redirect && (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
  assign mem_addr = pc;
  assign push = inflight && !kill && !redirect;
`ifdef PREFETCH_BYPASS_EN
  assign byp = push && count == '0;
`else
  assign byp = 1'b0;
`endif
  assign instr_valid = count != '0 || byp;
  assign pop = instr_valid && instr_ready && !redirect;
  always_comb begin
    head = '1;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) == count - CW'(1)) head = q[i];
  end
  assign instr = count != '0 ? head : byp ? mem_data : {WIDTH{1'b1}};
  always_comb begin
    en = '0;
    for (int i = 0; i < DEPTH; i++)
      en[i] = push && (pop ? CW'(i) < count : CW'(i) <= count);
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc <= '0;
      count <= '0;
      inflight <= 1'b0;
      kill <= 1'b0;
    end else begin
      pc <= redirect ? redirect_addr : pc + ADDR_WIDTH'(mem_rd);
      count <= redirect ? '0 : count + CW'(push && !pop) - CW'(pop && !push);
      inflight <= mem_rd;
      kill <= redirect && inflight;
    end
endmodule

// File: tb/tb_prefetch_ctrl.sv
// tb_prefetch_ctrl: directed self-checking bench for prefetch_ctrl
module tb_prefetch_ctrl;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int AW = 12;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect = 1'b0;
  logic instr_ready = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic mem_rd;
  logic [AW-1:0] mem_addr;
  logic [WIDTH-1:0] mem_data = '0;
  logic [WIDTH-1:0] instr;
  logic instr_valid;
  int vec = 0;
  int err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem_rd ? mem_addr[7:0] : 8'hEE;
  prefetch_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );
  always @(negedge clk)
    if (!rst && dut.push && !dut.pop && int'(dut.count) >= DEPTH) begin
      err++;
      $display("FAIL overflow push into full buffer count=%0d", dut.count);
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect = 1'b0;
    instr_ready = rdy;
    cyc();
    cyc();
    cyc();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    instr_ready = 1'b0;
    cyc();
    cyc();
    smp();
    vec++; if (mem_rd !== 1'b0) begin err++; $display("FAIL rst_mem_rd got %b exp 0", mem_rd); end
    vec++; if (instr_valid !== 1'b0) begin err++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    vec++; if (instr !== 8'hFF) begin err++; $display("FAIL rst_instr got %h exp ff", instr); end
    cyc();
    rst = 1'b0;
    smp();
    vec++; if (mem_rd !== 1'b1 || mem_addr !== 12'h000) begin err++; $display("FAIL rst_first_rd got %b/%h exp 1/000", mem_rd, mem_addr); end
  endtask
  task automatic test_stream();
    int first;
    first = BYP ? 1 : 2;
    do_reset(1'b1);
    smp();
    vec++; if (mem_rd !== 1'b1 || mem_addr !== 12'h000) begin err++; $display("FAIL stream_rd0 got %b/%h exp 1/000", mem_rd, mem_addr); end
    for (int k = 1; k < 10; k++) begin
      cyc();
      smp();
      vec++; if (instr_valid !== (k >= first)) begin err++; $display("FAIL stream_valid k=%0d got %b exp %b", k, instr_valid, k >= first); end
      vec++; if (instr !== (k >= first ? 8'(k - first) : 8'hFF)) begin err++; $display("FAIL stream_instr k=%0d got %h exp %h", k, instr, k >= first ? 8'(k - first) : 8'hFF); end
    end
  endtask
  task automatic test_backpressure();
    int n;
    n = 0;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      smp();
      if (mem_rd) begin
        vec++; if (mem_addr !== AW'(n)) begin err++; $display("FAIL bp_addr got %h exp %h", mem_addr, AW'(n)); end
        n++;
      end
      cyc();
    end
    smp();
    vec++; if (n !== 4) begin err++; $display("FAIL bp_rd_count got %0d exp 4", n); end
    vec++; if (dut.count !== 3'd4) begin err++; $display("FAIL bp_count got %0d exp 4", dut.count); end
    vec++; if (mem_rd !== 1'b0) begin err++; $display("FAIL bp_rd_full got %b exp 0", mem_rd); end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vec++; if (instr_valid !== 1'b1 || instr !== 8'(k)) begin err++; $display("FAIL bp_drain k=%0d got %b/%h exp 1/%h", k, instr_valid, instr, 8'(k)); end
      cyc();
      smp();
    end
  endtask
  task automatic test_push_pop();
    cyc();
    redirect = 1'b1;
    redirect_addr = 12'h020;
    instr_ready = 1'b0;
    smp();
    vec++; if (mem_rd !== 1'b0) begin err++; $display("FAIL pp_redirect_rd got %b exp 0", mem_rd); end
    cyc();
    redirect = 1'b0;
    smp();
    vec++; if (mem_rd !== 1'b1 || mem_addr !== 12'h020) begin err++; $display("FAIL pp_rd got %b/%h exp 1/020", mem_rd, mem_addr); end
    vec++; if (instr_valid !== 1'b0) begin err++; $display("FAIL pp_flush got %b exp 0", instr_valid); end
    cyc();
    smp();
    vec++; if (instr_valid !== BYP) begin err++; $display("FAIL pp_t2_valid got %b exp %b", instr_valid, BYP); end
    cyc();
    smp();
    vec++; if (instr_valid !== 1'b1 || instr !== 8'h20) begin err++; $display("FAIL pp_t3 got %b/%h exp 1/20", instr_valid, instr); end
    cyc();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      vec++; if (dut.count !== 3'd2) begin err++; $display("FAIL pp_count k=%0d got %0d exp 2", k, dut.count); end
      vec++; if (instr !== 8'(8'h20 + k)) begin err++; $display("FAIL pp_instr k=%0d got %h exp %h", k, instr, 8'(8'h20 + k)); end
      cyc();
    end
  endtask
  task automatic test_redirect_inflight();
    redirect = 1'b1;
    redirect_addr = 12'h003;
    instr_ready = 1'b1;
    cyc();
    redirect = 1'b0;
    cyc();
    cyc();
    smp();
    vec++; if (mem_rd !== 1'b1 || mem_addr !== 12'h005) begin err++; $display("FAIL ri_rd5 got %b/%h exp 1/005", mem_rd, mem_addr); end
    cyc();
    redirect = 1'b1;
    redirect_addr = 12'h100;
    smp();
    vec++; if (mem_rd !== 1'b0) begin err++; $display("FAIL ri_redirect_rd got %b exp 0", mem_rd); end
    cyc();
    redirect = 1'b0;
    smp();
    vec++; if (mem_rd !== 1'b1 || mem_addr !== 12'h100) begin err++; $display("FAIL ri_rd100 got %b/%h exp 1/100", mem_rd, mem_addr); end
    vec++; if (instr_valid !== 1'b0) begin err++; $display("FAIL ri_drop got %b/%h exp 0", instr_valid, instr); end
    cyc();
    smp();
    vec++; if (instr_valid !== BYP || (BYP && instr !== 8'h00)) begin err++; $display("FAIL ri_t2 got %b/%h exp %b", instr_valid, instr, BYP); end
    cyc();
    smp();
    vec++; if (instr_valid !== 1'b1 || instr !== (BYP ? 8'h01 : 8'h00)) begin err++; $display("FAIL ri_first got %b/%h exp 1/%h", instr_valid, instr, BYP ? 8'h01 : 8'h00); end
  endtask
  task automatic test_reset_mid();
    cyc();
    redirect = 1'b1;
    redirect_addr = 12'h000;
    instr_ready = 1'b0;
    cyc();
    redirect = 1'b0;
    cyc();
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    smp();
    vec++; if (dut.count !== 3'd3 || dut.inflight !== 1'b1) begin err++; $display("FAIL rm_setup got %0d/%b exp 3/1", dut.count, dut.inflight); end
    vec++; if (mem_rd !== 1'b0) begin err++; $display("FAIL rm_rd got %b exp 0", mem_rd); end
    cyc();
    rst = 1'b0;
    smp();
    vec++; if (instr_valid !== 1'b0 || instr !== 8'hFF) begin err++; $display("FAIL rm_out got %b/%h exp 0/ff", instr_valid, instr); end
    vec++; if (mem_rd !== 1'b1 || mem_addr !== 12'h000) begin err++; $display("FAIL rm_rd0 got %b/%h exp 1/000", mem_rd, mem_addr); end
    cyc();
    smp();
    vec++; if (mem_rd !== 1'b1 || mem_addr !== 12'h001 || instr_valid !== BYP) begin err++; $display("FAIL rm_t1 got %b/%h/%b exp 1/001/%b", mem_rd, mem_addr, instr_valid, BYP); end
    cyc();
    smp();
    vec++; if (instr_valid !== 1'b1 || instr !== 8'h00) begin err++; $display("FAIL rm_first got %b/%h exp 1/00", instr_valid, instr); end
  endtask
  task automatic test_bypass();
`ifdef PREFETCH_BYPASS_EN
    cyc();
    redirect = 1'b1;
    redirect_addr = 12'h040;
    instr_ready = 1'b1;
    cyc();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      smp();
      vec++; if (instr_valid !== 1'b1 || instr !== 8'(8'h40 + k)) begin err++; $display("FAIL byp_instr k=%0d got %b/%h exp 1/%h", k, instr_valid, instr, 8'(8'h40 + k)); end
      vec++; if (dut.count !== 3'd0) begin err++; $display("FAIL byp_count k=%0d got %0d exp 0", k, dut.count); end
    end
`endif
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_push_pop();
    test_redirect_inflight();
    test_reset_mid();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
